// File: rtl/pipe_mw_skid.sv
// MEM->WB pipeline stage: 2-entry skid buffer, write-back data select,
// RF forwarding lookups and a retired-instruction counter.
module pipe_mw_skid #(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5,
  parameter int CNT_W  = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_npc,
  input  logic [DATA_W-1:0] in_aluc,
  input  logic [DATA_W-1:0] in_mul_res,
  input  logic [DATA_W-1:0] in_dm_rdata,
  input  logic              in_lw,
  input  logic              in_jal,
  input  logic              in_mul,
  input  logic              in_rf_wena,
  input  logic [REG_AW-1:0] in_rf_waddr,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_npc,
  output logic [DATA_W-1:0] out_aluc,
  output logic [DATA_W-1:0] out_mul_res,
  output logic [DATA_W-1:0] out_dm_rdata,
  output logic              out_lw,
  output logic              out_jal,
  output logic              out_mul,
  output logic              out_rf_wena,
  output logic [REG_AW-1:0] out_rf_waddr,
  output logic              wb_we,
  output logic [DATA_W-1:0] wb_wdata,
  input  logic [REG_AW-1:0] fwd_raddr_a,
  input  logic [REG_AW-1:0] fwd_raddr_b,
  output logic              fwd_hit_a,
  output logic              fwd_hit_b,
  output logic [DATA_W-1:0] fwd_data_a,
  output logic [DATA_W-1:0] fwd_data_b,
  output logic [CNT_W-1:0]  retire_cnt
);
  typedef struct packed {
    logic [DATA_W-1:0] npc;
    logic [DATA_W-1:0] aluc;
    logic [DATA_W-1:0] mul_res;
    logic [DATA_W-1:0] dm_rdata;
    logic              lw;
    logic              jal;
    logic              mul;
    logic              rf_wena;
    logic [REG_AW-1:0] rf_waddr;
  } ent_t;

  // bit0 = head valid, bit1 = skid valid, so in_ready is a plain flop output
  typedef enum logic [1:0] {EMPTY = 2'b00, ONE = 2'b01, FULL = 2'b11} state_t;

  state_t state, state_nxt;
  ent_t   h, s, in_ent;
  logic   hv, sv, accept, pop, load_h, load_s, h_from_s;

  function automatic logic [DATA_W-1:0] wb_sel(input ent_t e);
    if (e.lw)       return e.dm_rdata;
    else if (e.jal) return e.npc;
    else if (e.mul) return e.mul_res;
    else            return e.aluc;
  endfunction

  function automatic logic fwd_match(input logic v, input ent_t e, input logic [REG_AW-1:0] a);
    return v && e.rf_wena && (e.rf_waddr == a) && (a != '0);
  endfunction

  assign in_ent = '{npc: in_npc, aluc: in_aluc, mul_res: in_mul_res, dm_rdata: in_dm_rdata,
                    lw: in_lw, jal: in_jal, mul: in_mul, rf_wena: in_rf_wena,
                    rf_waddr: in_rf_waddr};

  assign hv       = state[0];
  assign sv       = state[1];
  assign in_ready = ~sv;
  assign accept   = in_valid & in_ready;
  assign pop      = hv & out_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= EMPTY;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    load_h    = 1'b0;
    load_s    = 1'b0;
    h_from_s  = 1'b0;
    case (state)
      EMPTY: if (accept) begin load_h = 1'b1; state_nxt = ONE; end
      ONE: begin
        if (accept && pop)  load_h = 1'b1;
        else if (accept)    begin load_s = 1'b1; state_nxt = FULL; end
        else if (pop)       state_nxt = EMPTY;
      end
      FULL: if (pop) begin h_from_s = 1'b1; state_nxt = ONE; end
      default: state_nxt = EMPTY;
    endcase
    // flush wins: the pop (if any) still commits via retire_cnt/wb_we
    if (flush) begin
      state_nxt = EMPTY;
      load_h    = 1'b0;
      load_s    = 1'b0;
      h_from_s  = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      h <= '0;
      s <= '0;
    end else begin
      if (load_h)        h <= in_ent;
      else if (h_from_s) h <= s;
      if (load_s)        s <= in_ent;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)      retire_cnt <= '0;
    else if (pop) retire_cnt <= retire_cnt + CNT_W'(1);
  end

  assign out_valid    = hv;
  assign out_npc      = h.npc;
  assign out_aluc     = h.aluc;
  assign out_mul_res  = h.mul_res;
  assign out_dm_rdata = h.dm_rdata;
  assign out_lw       = h.lw;
  assign out_jal      = h.jal;
  assign out_mul      = h.mul;
  assign out_rf_wena  = h.rf_wena;
  assign out_rf_waddr = h.rf_waddr;

  assign wb_we    = pop & h.rf_wena & (h.rf_waddr != '0);
  assign wb_wdata = hv ? wb_sel(h) : '0;

  // skid entry is younger, so it wins over the head
  always_comb begin
    fwd_hit_a  = 1'b0;
    fwd_data_a = '0;
    fwd_hit_b  = 1'b0;
    fwd_data_b = '0;
    if (fwd_match(sv, s, fwd_raddr_a))      begin fwd_hit_a = 1'b1; fwd_data_a = wb_sel(s); end
    else if (fwd_match(hv, h, fwd_raddr_a)) begin fwd_hit_a = 1'b1; fwd_data_a = wb_sel(h); end
    if (fwd_match(sv, s, fwd_raddr_b))      begin fwd_hit_b = 1'b1; fwd_data_b = wb_sel(s); end
    else if (fwd_match(hv, h, fwd_raddr_b)) begin fwd_hit_b = 1'b1; fwd_data_b = wb_sel(h); end
  end
endmodule

// File: tb/tb_pipe_mw_skid.sv
// Scoreboard bench for pipe_mw_skid: queue-based reference of the 2-deep buffer.
module tb_pipe_mw_skid;
  localparam int DW = 32;
  localparam int AW = 5;
  localparam int CW = 2;

  typedef struct packed {
    logic [DW-1:0] npc;
    logic [DW-1:0] aluc;
    logic [DW-1:0] mul_res;
    logic [DW-1:0] dm;
    logic          lw;
    logic          jal;
    logic          mul;
    logic          we;
    logic [AW-1:0] wa;
  } ent_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  ent_t          cur;
  logic          in_valid, out_ready, flush;
  logic [AW-1:0] ra, rb;
  logic          in_ready, out_valid, out_lw, out_jal, out_mul, out_rf_wena, wb_we;
  logic          fwd_hit_a, fwd_hit_b;
  logic [DW-1:0] out_npc, out_aluc, out_mul_res, out_dm_rdata, wb_wdata, fwd_data_a, fwd_data_b;
  logic [AW-1:0] out_rf_waddr;
  logic [CW-1:0] retire_cnt;

  pipe_mw_skid #(.DATA_W(DW), .REG_AW(AW), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_npc(cur.npc), .in_aluc(cur.aluc), .in_mul_res(cur.mul_res), .in_dm_rdata(cur.dm),
    .in_lw(cur.lw), .in_jal(cur.jal), .in_mul(cur.mul), .in_rf_wena(cur.we),
    .in_rf_waddr(cur.wa), .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
    .out_npc(out_npc), .out_aluc(out_aluc), .out_mul_res(out_mul_res),
    .out_dm_rdata(out_dm_rdata), .out_lw(out_lw), .out_jal(out_jal), .out_mul(out_mul),
    .out_rf_wena(out_rf_wena), .out_rf_waddr(out_rf_waddr), .wb_we(wb_we),
    .wb_wdata(wb_wdata), .fwd_raddr_a(ra), .fwd_raddr_b(rb), .fwd_hit_a(fwd_hit_a),
    .fwd_hit_b(fwd_hit_b), .fwd_data_a(fwd_data_a), .fwd_data_b(fwd_data_b),
    .retire_cnt(retire_cnt)
  );

  ent_t ref_q[$];
  ent_t sb[$];
  ent_t mon_e;
  int   exp_cnt = 0;
  int   n_vec = 0;
  int   n_err = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [DW-1:0] wbv(input ent_t e);
    if (e.lw)  return e.dm;
    if (e.jal) return e.npc;
    if (e.mul) return e.mul_res;
    return e.aluc;
  endfunction

  // youngest matching held entry supplies the data
  function automatic void fwd_ref(input logic [AW-1:0] a, output logic hit, output logic [DW-1:0] d);
    hit = 1'b0;
    d   = '0;
    if (a != '0)
      for (int i = 0; i < ref_q.size(); i++)
        if (ref_q[i].we && ref_q[i].wa == a) begin hit = 1'b1; d = wbv(ref_q[i]); end
  endfunction

  function automatic ent_t mk(input logic [DW-1:0] a, input logic [AW-1:0] w);
    ent_t e = '0;
    e.aluc = a;
    e.wa   = w;
    e.we   = 1'b1;
    return e;
  endfunction

  // one cycle: check state-level predictions before the edge, then update the model
  task automatic step();
    logic pop_m, acc_m, h;
    logic [DW-1:0] d;
    @(negedge clk);
    chk("out_valid", 64'(out_valid), 64'(ref_q.size() > 0));
    chk("in_ready", 64'(in_ready), 64'(ref_q.size() < 2));
    chk("retire_cnt", 64'(retire_cnt), 64'(exp_cnt % (1 << CW)));
    pop_m = (ref_q.size() > 0) && out_ready;
    acc_m = in_valid && (ref_q.size() < 2);
    chk("wb_we", 64'(wb_we), 64'(pop_m && ref_q[0].we && ref_q[0].wa != 0));
    fwd_ref(ra, h, d);
    chk("fwd_hit_a", 64'(fwd_hit_a), 64'(h));
    chk("fwd_data_a", 64'(fwd_data_a), 64'(d));
    fwd_ref(rb, h, d);
    chk("fwd_hit_b", 64'(fwd_hit_b), 64'(h));
    chk("fwd_data_b", 64'(fwd_data_b), 64'(d));
    @(posedge clk);
    #1;
    if (pop_m) begin void'(ref_q.pop_front()); exp_cnt++; end
    if (flush) begin ref_q.delete(); sb.delete(); end
    else if (acc_m) begin ref_q.push_back(cur); sb.push_back(cur); end
  endtask

  // monitor: every committed head must be the oldest outstanding entry
  initial forever begin
    @(negedge clk);
    if (!rst && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL sb_underflow: got aluc %0h expected no entry at %0t", out_aluc, $time);
      end else begin
        mon_e = sb.pop_front();
        chk("out_aluc", 64'(out_aluc), 64'(mon_e.aluc));
        chk("out_npc", 64'(out_npc), 64'(mon_e.npc));
        chk("out_mul_res", 64'(out_mul_res), 64'(mon_e.mul_res));
        chk("out_dm_rdata", 64'(out_dm_rdata), 64'(mon_e.dm));
        chk("out_sel", 64'({out_lw, out_jal, out_mul, out_rf_wena}),
            64'({mon_e.lw, mon_e.jal, mon_e.mul, mon_e.we}));
        chk("out_rf_waddr", 64'(out_rf_waddr), 64'(mon_e.wa));
        chk("wb_wdata", 64'(wb_wdata), 64'(wbv(mon_e)));
      end
    end
  end

  initial begin
    logic [DW-1:0] exp_d;
    in_valid = 1'b0; out_ready = 1'b0; flush = 1'b0; cur = '0; ra = '0; rb = '0;
    #12;
    chk("rst_out_valid", 64'(out_valid), 64'(0));
    chk("rst_in_ready", 64'(in_ready), 64'(1));
    chk("rst_wb_wdata", 64'(wb_wdata), 64'(0));
    chk("rst_retire_cnt", 64'(retire_cnt), 64'(0));
    rst = 1'b0;
    @(posedge clk);
    #1;

    // streaming 5 entries; 2-bit counter wraps to 1
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      cur = mk(DW'(32'h11 * (i + 1)), AW'(i + 1));
      in_valid = 1'b1;
      step();
    end
    in_valid = 1'b0;
    step();
    step();
    #3 chk("wrap_cnt", 64'(retire_cnt), 64'(1));

    // stall / skid
    out_ready = 1'b0;
    cur = mk(32'hA, 1); in_valid = 1'b1; step();
    cur = mk(32'hB, 2); step();
    in_valid = 1'b0;
    #3 chk("skid_in_ready", 64'(in_ready), 64'(0));
    chk("skid_head", 64'(out_aluc), 64'(32'hA));
    out_ready = 1'b1;
    step(); step(); step();

    // write-back mux priority
    for (int i = 0; i < 4; i++) begin
      cur = mk(32'hF, 3);
      cur.dm = 32'hD; cur.npc = 32'hC; cur.mul_res = 32'hE;
      cur.lw = (i == 0); cur.jal = (i <= 1); cur.mul = (i <= 2);
      case (i)
        0: exp_d = 32'hD;
        1: exp_d = 32'hC;
        2: exp_d = 32'hE;
        default: exp_d = 32'hF;
      endcase
      out_ready = 1'b0; in_valid = 1'b1; step();
      in_valid = 1'b0;
      #3 chk("mux_prio", 64'(wb_wdata), 64'(exp_d));
      out_ready = 1'b1; step();
    end

    // forwarding: skid entry beats head, address 0 never hits
    out_ready = 1'b0; in_valid = 1'b1;
    cur = mk(32'h55, 5); step();
    cur = mk(32'h66, 5); step();
    in_valid = 1'b0; ra = 5; rb = 0;
    #3 chk("fwd_a_hit", 64'(fwd_hit_a), 64'(1));
    chk("fwd_a_data", 64'(fwd_data_a), 64'(32'h66));
    chk("fwd_b_hit", 64'(fwd_hit_b), 64'(0));
    chk("fwd_b_data", 64'(fwd_data_b), 64'(0));

    // flush in FULL with a pop and an incoming entry
    cur = mk(32'h77, 7); in_valid = 1'b1; out_ready = 1'b1; flush = 1'b1;
    step();
    flush = 1'b0; in_valid = 1'b0;
    #3 chk("flush_empty", 64'(out_valid), 64'(0));
    chk("flush_in_ready", 64'(in_ready), 64'(1));
    step();

    // rf_wena=0 entry never forwards
    out_ready = 1'b0; cur = mk(32'h88, 9); cur.we = 1'b0; in_valid = 1'b1; step();
    in_valid = 1'b0; ra = 9;
    #3 chk("fwd_nowe_hit", 64'(fwd_hit_a), 64'(0));
    chk("fwd_nowe_data", 64'(fwd_data_a), 64'(0));
    out_ready = 1'b1; step();

    // randomized traffic
    for (int n = 0; n < 400; n++) begin
      cur.npc = $urandom(); cur.aluc = $urandom(); cur.mul_res = $urandom(); cur.dm = $urandom();
      cur.lw = ($urandom_range(0, 3) == 0); cur.jal = ($urandom_range(0, 3) == 0);
      cur.mul = ($urandom_range(0, 3) == 0); cur.we = ($urandom_range(0, 4) != 0);
      cur.wa = AW'($urandom_range(0, 7));
      in_valid  = ($urandom_range(0, 9) < 7);
      out_ready = ($urandom_range(0, 9) < 6);
      flush     = ($urandom_range(0, 31) == 0);
      ra = AW'($urandom_range(0, 7));
      rb = AW'($urandom_range(0, 7));
      step();
    end
    flush = 1'b0;

    // asynchronous reset mid-cycle while FULL
    out_ready = 1'b0; in_valid = 1'b1;
    cur = mk(32'h99, 4); step();
    cur = mk(32'hAA, 4); step();
    ra = 4; rb = 4; out_ready = 1'b1; in_valid = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk("arst_out_valid", 64'(out_valid), 64'(0));
    chk("arst_in_ready", 64'(in_ready), 64'(1));
    chk("arst_wb_we", 64'(wb_we), 64'(0));
    chk("arst_wb_wdata", 64'(wb_wdata), 64'(0));
    chk("arst_fwd", 64'({fwd_hit_a, fwd_hit_b}), 64'(0));
    chk("arst_fwd_data", 64'(fwd_data_a), 64'(0));
    chk("arst_cnt", 64'(retire_cnt), 64'(0));
    ref_q.delete(); sb.delete(); exp_cnt = 0;
    #3 rst = 1'b0;
    @(posedge clk);
    #1;
    cur = mk(32'hBB, 6); in_valid = 1'b1; step();
    in_valid = 1'b0; step(); step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/pipe_mw_skid.md
# pipe_mw_skid

Parametrised MEM→WB pipeline stage with a valid/ready handshake, a 2-entry skid buffer, write-back data selection, a register-file forwarding port and a retired-instruction counter. It sits between the MEM stage (data memory, multiplier) and the register-file write port. It lets WB stall, for example on a busy RF port, without a combinational ready path back into MEM. It also lets the pipeline be flushed at the MEM/WB boundary.

## Interface
Parameters:
- DATA_W, 32, width of npc, aluc, mul_res, dm_rdata and write-back data
- REG_AW, 5, register-file address width
- CNT_W, 32, retired-instruction counter width

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- in_valid  in  1  MEM entry valid
- in_ready  out  1  stage can accept; registered, equals NOT skid-valid
- in_npc, in_aluc, in_mul_res, in_dm_rdata  in  DATA_W each  MEM payload data
- in_lw, in_jal, in_mul  in  1 each  write-back source selects
- in_rf_wena  in  1  RF write enable
- in_rf_waddr  in  REG_AW  RF write address
- flush  in  1  synchronous discard of all held entries
- out_valid  out  1  head entry valid
- out_ready  in  1  WB can consume head
- out_npc, out_aluc, out_mul_res, out_dm_rdata, out_lw, out_jal, out_mul, out_rf_wena, out_rf_waddr  out  as inputs  head-entry payload
- wb_we  out  1  RF write strobe = out_valid & out_ready & out_rf_wena & (out_rf_waddr != 0)
- wb_wdata  out  DATA_W  selected head write-back data
- fwd_raddr_a, fwd_raddr_b  in  REG_AW  forwarding lookup addresses
- fwd_hit_a, fwd_hit_b  out  1  lookup matched a held entry
- fwd_data_a, fwd_data_b  out  DATA_W  forwarded data, 0 when no hit
- retire_cnt  out  CNT_W  committed-entry count

## Operation
- Storage: head register H (drives out_*), skid register S, valid bits hv and sv.
- accept = in_valid & in_ready. pop = hv & out_ready. out_valid = hv.
- States: EMPTY (hv=0, sv=0), ONE (hv=1, sv=0), FULL (hv=1, sv=1). The state hv=0, sv=1 is illegal and never reached.
- EMPTY: accept → H<=in, ONE.
- ONE: accept&pop → H<=in, ONE. accept&~pop → S<=in, FULL. ~accept&pop → EMPTY. Idle → hold.
- FULL: in_ready=0. pop → H<=S, ONE. ~pop → hold.
- flush: at the next edge hv<=0 and sv<=0 (EMPTY); the entry accepted that cycle is discarded. A pop in the flush cycle still commits: wb_we stays as computed and the counter increments. flush has priority over every other transition.
- Write-back mux, priority lw > jal > mul > alu: lw→dm_rdata, jal→npc, mul→mul_res, else aluc. The same function applies to H (giving wb_wdata) and to S (for forwarding).
- Forwarding, per port x:
  - S candidate: sv & S.rf_wena & S.rf_waddr==fwd_raddr_x & fwd_raddr_x!=0.
  - H candidate: same conditions on hv and H.
  - S, the younger entry, wins over H. hit=1 and data=winner's mux value. No candidate → hit=0, data=0.
  - Lookups are purely combinational on current state.
- retire_cnt increments by 1 on each pop, wraps modulo 2^CNT_W, and does not count flushed entries.
- Payload registers of invalid entries are don't-care internally. Every output is qualified by the valid bits except out_* payload, which shows H contents.

## Timing
- Reset, asynchronous: hv, sv, all H/S payload and retire_cnt = 0. Consequently out_valid=0, in_ready=1, wb_we=0, wb_wdata=0, fwd_hit_*=0, fwd_data_*=0.
- Latency: input accepted at edge N is visible on out_* after edge N when EMPTY or popped-while-ONE, one stage per entry.
- Throughput: 1 entry/cycle with out_ready held high.
- in_ready is a pure register output with no combinational path from out_ready.
- After an out_ready stall, in_ready drops one cycle later (FULL). It recovers the cycle after the first pop.
- Ordering is strictly FIFO; no entry is lost or duplicated except through flush.
- Reset mid-stream drops all entries immediately, regardless of clk.

## Test plan
- Streaming: 4 ALU entries aluc=0x11..0x44, waddr=1..4, out_ready=1. Expect out on consecutive cycles, 1-cycle latency, wb_we=1 each cycle, wb_wdata=0x11..0x44 in order, retire_cnt=4.
- Stall/skid: out_ready=0 while sending A(aluc=0xA), then B(0xB). Expect in_ready=0 after B is accepted and out shows A. Raise out_ready: A then B retire, and in_ready returns to 1 the cycle after A pops.
- Mux priority: one entry with lw=jal=mul=1, dm_rdata=0xD, npc=0xC, mul_res=0xE → wb_wdata=0xD. Then jal=mul=1 → 0xC, mul=1 → 0xE, none → aluc.
- Forwarding: FULL with H waddr=5 data=0x55 and S waddr=5 data=0x66, fwd_raddr_a=5 → hit, 0x66. fwd_raddr_b=0 → hit=0, data=0. Entry with rf_wena=0 → no hit.
- Flush: in FULL, assert flush with out_ready=1 and in_valid=1. Expect the head committed (retire_cnt+1), then EMPTY next cycle, in_ready=1, and the incoming entry never appears.
- Reset mid-operation and wrap: with CNT_W=2, retire 5 entries → retire_cnt=1. Assert rst asynchronously mid-cycle → all outputs 0 and in_ready=1 without waiting for a clk edge.
